// File: rtl/servo_cmd_ctrl_pkg.sv
// Shared types, default constants and pulse-width derivations for the servo
// command controller.
package servo_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CALC
  } state_e;

  localparam int unsigned ANGLE_W           = 8;
  localparam int unsigned DEF_PERIOD_CYC    = 500000;
  localparam int unsigned DEF_MIN_PULSE_CYC = 25000;
  localparam int unsigned DEF_STEP_CYC      = 139;
  localparam int unsigned DEF_MAX_ANGLE     = 180;
  localparam int unsigned DEF_SLEW_CYC      = 2500;

  function automatic logic [31:0] center_cyc(input int unsigned min_p,
                                             input int unsigned step,
                                             input int unsigned max_a);
    return 32'(min_p + (max_a / 2) * step);
  endfunction

  function automatic logic [31:0] max_pulse_cyc(input int unsigned min_p,
                                                input int unsigned step,
                                                input int unsigned max_a);
    return 32'(min_p + max_a * step);
  endfunction

  localparam logic [31:0] CENTER_CYC =
    center_cyc(DEF_MIN_PULSE_CYC, DEF_STEP_CYC, DEF_MAX_ANGLE);
  localparam logic [31:0] MAX_PULSE_CYC =
    max_pulse_cyc(DEF_MIN_PULSE_CYC, DEF_STEP_CYC, DEF_MAX_ANGLE);

endpackage

// File: rtl/servo_cmd_ctrl_if.sv
// Angle command handshake: the master offers an angle, the controller accepts
// it when ready.
interface servo_cmd_ctrl_if;

  logic                           cmd_valid;
  logic [servo_pkg::ANGLE_W-1:0]  cmd_angle;
  logic                           cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_angle,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_angle,
    output cmd_ready
  );

endinterface

// File: rtl/servo_cmd_ctrl_frame_timer.sv
// Free-running PWM frame counter; restarts with rst_n so it stays aligned with
// the downstream PWM counter.
module frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYC = DEF_PERIOD_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] count,
  output logic        tick
);

  localparam logic [31:0] LAST_CNT = 32'(PERIOD_CYC - 1);

  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (count_q == LAST_CNT) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count = count_q;
  assign tick  = (count_q == LAST_CNT);

endmodule

// File: rtl/servo_cmd_ctrl.sv
// Servo angle command controller: accepts angle commands, converts them to a
// pulse-width target and slews the PWM duty toward it once per frame.
module servo_cmd_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_CYC    = DEF_PERIOD_CYC,
  parameter int unsigned MIN_PULSE_CYC = DEF_MIN_PULSE_CYC,
  parameter int unsigned STEP_CYC      = DEF_STEP_CYC,
  parameter int unsigned MAX_ANGLE     = DEF_MAX_ANGLE,
  parameter int unsigned SLEW_CYC      = DEF_SLEW_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  servo_cmd_ctrl_if.slave        cmd,
  output logic [31:0]            duty_cycle,
  output logic [31:0]            period,
  output logic                   frame_tick,
  output logic                   busy,
  output logic                   angle_err
);

  localparam logic [31:0]        CENTER_L = center_cyc(MIN_PULSE_CYC, STEP_CYC, MAX_ANGLE);
  localparam logic [31:0]        MIN_L    = 32'(MIN_PULSE_CYC);
  localparam logic [31:0]        STEP_L   = 32'(STEP_CYC);
  localparam logic [31:0]        SLEW_L   = 32'(SLEW_CYC);
  localparam logic [ANGLE_W-1:0] MAXA_L   = ANGLE_W'(MAX_ANGLE);

  logic [31:0]        unused_frame_cnt;
  logic               tick;

  state_e             state_q;
  logic               ready_q;
  logic               err_q;
  logic               pending_q;
  logic               armed_q;
  logic               busy_q;
  logic [ANGLE_W-1:0] angle_q;
  logic [31:0]        target_q;
  logic [31:0]        cur_q;
  logic [31:0]        duty_q;

  logic [31:0]        target_d;
  logic [31:0]        cur_d;
  logic               armed_d;
  logic               handshake;

  frame_timer #(
    .PERIOD_CYC (PERIOD_CYC)
  ) u_frame_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .count (unused_frame_cnt),
    .tick  (tick)
  );

  assign handshake = cmd.cmd_valid && ready_q;

  // The slew step reads target_q, so a target written in the same cycle as
  // the tick only takes effect on the following frame.
  always_comb begin
    cur_d = cur_q;
    if (tick) begin
      if (target_q > cur_q) begin
        cur_d = ((target_q - cur_q) > SLEW_L) ? cur_q + SLEW_L : target_q;
      end else if (cur_q > target_q) begin
        cur_d = ((cur_q - target_q) > SLEW_L) ? cur_q - SLEW_L : target_q;
      end
    end
  end

  always_comb begin
    target_d = target_q;
    if (state_q == ST_CALC) begin
      target_d = MIN_L + 32'(angle_q) * STEP_L;
    end
  end

  assign armed_d = armed_q | (tick & pending_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      pending_q <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      angle_q   <= '0;
      target_q  <= CENTER_L;
      cur_q     <= CENTER_L;
      duty_q    <= '0;
    end else begin
      err_q    <= 1'b0;
      cur_q    <= cur_d;
      target_q <= target_d;
      armed_q  <= armed_d;
      busy_q   <= (cur_d != target_d);
      if (tick) begin
        duty_q <= armed_d ? cur_d : '0;
      end
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (handshake) begin
            angle_q <= (cmd.cmd_angle > MAXA_L) ? MAXA_L : cmd.cmd_angle;
            err_q   <= (cmd.cmd_angle > MAXA_L);
            ready_q <= 1'b0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          pending_q <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign duty_cycle    = duty_q;
  assign period        = 32'(PERIOD_CYC);
  assign frame_tick    = tick;
  assign busy          = busy_q;
  assign angle_err     = err_q;

endmodule

// File: tb/tb_servo_cmd_ctrl.sv
// Self-checking bench for servo_cmd_ctrl: directed scenarios plus random
// commands against an edge-indexed behavioural model.
module tb_servo_cmd_ctrl;

  localparam int unsigned P      = 1000;
  localparam int unsigned MINP   = 100;
  localparam int unsigned STEP   = 2;
  localparam int unsigned MAXA   = 180;
  localparam int unsigned SLEW   = 50;
  localparam int unsigned CENTER = MINP + (MAXA / 2) * STEP;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] duty_cycle;
  logic [31:0] period;
  logic        frame_tick;
  logic        busy;
  logic        angle_err;

  always #5 clk = ~clk;

  servo_cmd_ctrl_if cmd_if ();

  servo_cmd_ctrl #(
    .PERIOD_CYC    (P),
    .MIN_PULSE_CYC (MINP),
    .STEP_CYC      (STEP),
    .MAX_ANGLE     (MAXA),
    .SLEW_CYC      (SLEW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd_if),
    .duty_cycle (duty_cycle),
    .period     (period),
    .frame_tick (frame_tick),
    .busy       (busy),
    .angle_err  (angle_err)
  );

  // Model: each accepted command is recorded with the clock edge it was
  // accepted on; it governs frame ticks from two edges later onward.
  typedef struct {
    int          edge_n;
    int unsigned ang;
  } hs_t;

  hs_t         hs_q[$];
  int          j;
  int          last_hs_edge;
  int unsigned last_hs_ang;
  int unsigned cur_m;
  int unsigned duty_m;
  bit          ready_m;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned pulse_of(input int unsigned a);
    return MINP + ((a > MAXA) ? MAXA : a) * STEP;
  endfunction

  function automatic int unsigned target_at(input int lim);
    int unsigned t;
    t = CENTER;
    foreach (hs_q[i]) if (hs_q[i].edge_n <= lim) t = pulse_of(hs_q[i].ang);
    return t;
  endfunction

  function automatic bit armed_at(input int lim);
    return (hs_q.size() > 0) && (hs_q[0].edge_n <= lim);
  endfunction

  task automatic model_reset();
    hs_q.delete();
    j            = 0;
    last_hs_edge = 0;
    last_hs_ang  = 0;
    cur_m        = CENTER;
    duty_m       = 0;
    ready_m      = 1'b0;
  endtask

  // One clock: drive at negedge, advance model at posedge, compare at negedge.
  task automatic step(input bit v, input int unsigned a, input bit r);
    int          e;
    int unsigned tgt;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_angle = 8'(a);
    rst_n            = r;
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      e = j + 1;
      if (v && ready_m) begin
        hs_q.push_back('{edge_n: e, ang: a});
        last_hs_edge = e;
        last_hs_ang  = a;
      end
      if (e % P == 0) begin
        tgt = target_at(e - 2);
        if (tgt > cur_m) cur_m = cur_m + ((tgt - cur_m > SLEW) ? SLEW : tgt - cur_m);
        else             cur_m = cur_m - ((cur_m - tgt > SLEW) ? SLEW : cur_m - tgt);
        duty_m = armed_at(e - 2) ? cur_m : 0;
      end
      j = e;
    end
    @(negedge clk);
    ready_m = (j > 0) && (last_hs_edge != j);
    chk("cmd_ready", cmd_if.cmd_ready, ready_m);
    chk("frame_tick", frame_tick, (j % P == P - 1) ? 1 : 0);
    chk("duty_cycle", duty_cycle, duty_m);
    chk("busy", busy, (j > 0 && cur_m != target_at(j - 1)) ? 1 : 0);
    chk("angle_err", angle_err, (j > 0 && last_hs_edge == j && last_hs_ang > MAXA) ? 1 : 0);
    chk("period", period, P);
  endtask

  task automatic send(input int unsigned a);
    int k;
    k = 0;
    while (!ready_m && k < 10) begin
      step(1'b0, 0, 1'b1);
      k++;
    end
    if (!ready_m) chk("send_timeout", 0, 1);
    step(1'b1, a, 1'b1);
  endtask

  task automatic wait_ticks(input int n);
    int cnt;
    int k;
    cnt = 0;
    k   = 0;
    while (cnt < n && k < n * P + P) begin
      step(1'b0, 0, 1'b1);
      k++;
      if (j % P == 0) cnt++;
    end
    if (cnt < n) chk("tick_timeout", cnt, n);
  endtask

  task automatic send_on_tick(input int unsigned a);
    int k;
    k = 0;
    while (!(j % P == P - 1 && ready_m) && k < 2 * P) begin
      step(1'b0, 0, 1'b1);
      k++;
    end
    if (!(j % P == P - 1 && ready_m)) chk("align_timeout", 0, 1);
    step(1'b1, a, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned pick;
    int unsigned ang;
    n_checks         = 0;
    n_errors         = 0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_angle = '0;
    rst_n            = 1'b0;
    model_reset();
    @(negedge clk);

    repeat (3) step(1'b0, 0, 1'b0);
    chk("reset_duty", duty_cycle, 0);
    chk("reset_ready", cmd_if.cmd_ready, 0);

    // Three idle frames: disarmed output stays 0.
    repeat (3 * P) step(1'b0, 0, 1'b1);
    chk("idle_duty", duty_cycle, 0);

    send(90);
    wait_ticks(1);
    chk("arm_center", duty_cycle, CENTER);
    chk("arm_busy", busy, 0);

    send(180);
    wait_ticks(4);
    chk("slew_up_end", duty_cycle, 460);
    chk("slew_up_busy", busy, 0);

    send(200);
    chk("clamp_err", angle_err, 1);
    wait_ticks(1);
    chk("clamp_duty", duty_cycle, 460);

    send(90);
    wait_ticks(4);
    chk("back_center", duty_cycle, CENTER);

    // New command accepted on the tick cycle itself: that tick uses old target.
    send(180);
    send_on_tick(0);
    chk("tick_collide", duty_cycle, 330);
    wait_ticks(1);
    chk("after_collide", duty_cycle, 280);
    wait_ticks(1);
    chk("slew_down", duty_cycle, 230);

    // Reset pulse mid-frame during a slew.
    while (j % P != 500) step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    chk("midrst_duty", duty_cycle, 0);
    step(1'b0, 0, 1'b1);
    chk("midrst_ready", cmd_if.cmd_ready, 1);

    // Random commands, boundary-biased angles, occasional resets.
    repeat (14 * P) begin
      if ($urandom_range(0, 4999) == 0) begin
        step(1'b0, 0, 1'b0);
      end else begin
        pick = $urandom_range(0, 5);
        case (pick)
          0:       ang = 0;
          1:       ang = MAXA;
          2:       ang = MAXA + 1;
          3:       ang = 255;
          default: ang = $urandom_range(0, 255);
        endcase
        step(($urandom_range(0, 399) == 0) || (j % P == P - 1 && $urandom_range(0, 1) == 1),
             ang, 1'b1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
